gci_special_scanner: RTL and testbench

Host-side initiator for the GCI special-address space. After boot it walks every attached device's special memory, reads each device's USEMEMSIZE (special addr 0x00) and PRIORITY (0x01), allocates a contiguous memory window per device, and writes the assigned base back to the device (special addr 0x02). It sits in the GCI controller between the bus-enumeration sequencer and the per-device special ports, and keeps an allocation table the address decoder reads.

---
 rtl/gci_special_pkg.sv | 25 ++
 rtl/gci_special_scanner_if.sv | 21 ++
 rtl/gci_special_alloc_table.sv | 39 +++
 rtl/gci_special_scanner.sv | 198 +++++++++++++++++++
 tb/tb_gci_special_scanner.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gci_special_pkg.sv
// Shared constants and types for the GCI special-address scanner.
// Special address map, scanner state encoding and allocation-table entry layout.
package gci_special_pkg;

  localparam logic [7:0] ADDR_USEMEMSIZE = 8'h00;
  localparam logic [7:0] ADDR_PRIORITY   = 8'h01;
  localparam logic [7:0] ADDR_BASE       = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_SIZE = 3'd1,
    ST_RD_PRI  = 3'd2,
    ST_CALC    = 3'd3,
    ST_WR_BASE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] prio;
  } tbl_entry_t;

endpackage

// File: rtl/gci_special_scanner_if.sv
// Host-to-device special-port bus: one-hot select, request, direction, address and data.
interface gci_special_scanner_if #(
  parameter int DEVICE_NUM = 4
);
  logic [DEVICE_NUM-1:0] oSPECIAL_SEL;
  logic                  oSPECIAL_REQ;
  logic                  oSPECIAL_RW;
  logic [7:0]            oSPECIAL_ADDR;
  logic [31:0]           oSPECIAL_DATA;
  logic [31:0]           iSPECIAL_DATA;

  modport master (
    output oSPECIAL_SEL, oSPECIAL_REQ, oSPECIAL_RW, oSPECIAL_ADDR, oSPECIAL_DATA,
    input  iSPECIAL_DATA
  );

  modport slave (
    input  oSPECIAL_SEL, oSPECIAL_REQ, oSPECIAL_RW, oSPECIAL_ADDR, oSPECIAL_DATA,
    output iSPECIAL_DATA
  );
endinterface

// File: rtl/gci_special_alloc_table.sv
// Per-device allocation table: one write port, combinational read, synchronous clear.
// Out-of-range read indices return an all-zero entry.
module gci_special_alloc_table
  import gci_special_pkg::*;
#(
  parameter int DEVICE_NUM = 4
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       clr_i,
  input  logic       we_i,
  input  logic [3:0] widx_i,
  input  tbl_entry_t wentry_i,
  input  logic [3:0] ridx_i,
  output tbl_entry_t rentry_o
);

  tbl_entry_t tbl_q [DEVICE_NUM];

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < DEVICE_NUM; i++) tbl_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEVICE_NUM; i++) tbl_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < DEVICE_NUM; i++) begin
        if (widx_i == 4'(i)) tbl_q[i] <= wentry_i;
      end
    end
  end

  always_comb begin
    rentry_o = '0;
    for (int i = 0; i < DEVICE_NUM; i++) begin
      if (ridx_i == 4'(i)) rentry_o = tbl_q[i];
    end
  end

endmodule

// File: rtl/gci_special_scanner.sv
// Walks every device's special space: reads size and priority, allocates a window, writes the base back.
// Four cycles per device; all special-port outputs are registered from the next state.
module gci_special_scanner
  import gci_special_pkg::*;
#(
  parameter int          DEVICE_NUM  = 4,
  parameter logic [31:0] ALLOC_BASE  = 32'h0000_0000,
  parameter logic [31:0] ALLOC_LIMIT = 32'h0001_0000
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iSTART,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oERROR,
  gci_special_scanner_if.master sp,
  input  logic [3:0]            iTBL_ID,
  output logic                  oTBL_VALID,
  output logic [31:0]           oTBL_BASE,
  output logic [31:0]           oTBL_SIZE,
  output logic [31:0]           oTBL_PRIORITY
);

  localparam logic [3:0] LAST_IDX = 4'(DEVICE_NUM - 1);

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [31:0]           ptr_q, ptr_d;
  logic [31:0]           size_q, size_d;
  logic [31:0]           prio_q, prio_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DEVICE_NUM-1:0] sel_q, sel_d;
  logic                  req_q, req_d;
  logic                  rw_q, rw_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           data_q, data_d;

  logic [DEVICE_NUM-1:0] onehot_w;
  logic [32:0]           end_w;
  logic                  ovf_w;
  logic                  tbl_clr, tbl_we;
  tbl_entry_t            tbl_wentry, tbl_rentry;

  // 33-bit sum so a carry out of the pointer counts as overflow instead of wrapping.
  assign end_w = {1'b0, ptr_q} + {1'b0, size_q};
  assign ovf_w = err_q || (end_w > {1'b0, ALLOC_LIMIT});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    size_d     = size_q;
    prio_d     = prio_q;
    err_d      = err_q;
    tbl_clr    = 1'b0;
    tbl_we     = 1'b0;
    tbl_wentry = '0;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          tbl_clr = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          ptr_d   = ALLOC_BASE;
          state_d = ST_RD_SIZE;
        end
      end
      ST_RD_SIZE: begin
        size_d  = sp.iSPECIAL_DATA;
        state_d = ST_RD_PRI;
      end
      ST_RD_PRI: begin
        prio_d  = sp.iSPECIAL_DATA;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        tbl_we          = 1'b1;
        tbl_wentry.size = size_q;
        tbl_wentry.prio = prio_q;
        if (size_q != '0) begin
          if (ovf_w) begin
            err_d = 1'b1;
          end else begin
            tbl_wentry.valid = 1'b1;
            tbl_wentry.base  = ptr_q;
            ptr_d            = end_w[31:0];
          end
        end
        state_d = ST_WR_BASE;
      end
      ST_WR_BASE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_RD_SIZE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    onehot_w = '0;
    for (int i = 0; i < DEVICE_NUM; i++) onehot_w[i] = (idx_d == 4'(i));
  end

  // Port outputs are decoded from the next state so they are registered and stable across each access.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    sel_d  = '0;
    req_d  = 1'b0;
    rw_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    case (state_d)
      ST_RD_SIZE: begin
        req_d  = 1'b1;
        sel_d  = onehot_w;
        addr_d = ADDR_USEMEMSIZE;
      end
      ST_RD_PRI: begin
        req_d  = 1'b1;
        sel_d  = onehot_w;
        addr_d = ADDR_PRIORITY;
      end
      ST_WR_BASE: begin
        req_d  = 1'b1;
        rw_d   = 1'b1;
        sel_d  = onehot_w;
        addr_d = ADDR_BASE;
        data_d = tbl_wentry.base;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      size_q  <= '0;
      prio_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      size_q  <= size_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  gci_special_alloc_table #(.DEVICE_NUM(DEVICE_NUM)) u_table (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .clr_i    (tbl_clr),
    .we_i     (tbl_we),
    .widx_i   (idx_q),
    .wentry_i (tbl_wentry),
    .ridx_i   (iTBL_ID),
    .rentry_o (tbl_rentry)
  );

  assign oBUSY            = busy_q;
  assign oDONE            = done_q;
  assign oERROR           = err_q;
  assign sp.oSPECIAL_SEL  = sel_q;
  assign sp.oSPECIAL_REQ  = req_q;
  assign sp.oSPECIAL_RW   = rw_q;
  assign sp.oSPECIAL_ADDR = addr_q;
  assign sp.oSPECIAL_DATA = data_q;
  assign oTBL_VALID       = tbl_rentry.valid;
  assign oTBL_BASE        = tbl_rentry.base;
  assign oTBL_SIZE        = tbl_rentry.size;
  assign oTBL_PRIORITY    = tbl_rentry.prio;

endmodule

// File: tb/tb_gci_special_scanner.sv
// Drives scans against modelled devices and compares writes, timing and table contents to a reference allocation.
module tb_gci_special_scanner;

  localparam int          N     = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic        iCLOCK  = 1'b0;
  logic        inRESET = 1'b0;
  logic        iSTART  = 1'b0;
  logic [3:0]  iTBL_ID = 4'd0;
  logic        oBUSY, oDONE, oERROR, oTBL_VALID;
  logic [31:0] oTBL_BASE, oTBL_SIZE, oTBL_PRIORITY;

  gci_special_scanner_if #(.DEVICE_NUM(N)) sp();

  gci_special_scanner #(.DEVICE_NUM(N), .ALLOC_BASE(BASE), .ALLOC_LIMIT(LIMIT)) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iSTART        (iSTART),
    .oBUSY         (oBUSY),
    .oDONE         (oDONE),
    .oERROR        (oERROR),
    .sp            (sp),
    .iTBL_ID       (iTBL_ID),
    .oTBL_VALID    (oTBL_VALID),
    .oTBL_BASE     (oTBL_BASE),
    .oTBL_SIZE     (oTBL_SIZE),
    .oTBL_PRIORITY (oTBL_PRIORITY)
  );

  always #50 iCLOCK = ~iCLOCK;

  int cyc = 0;
  always @(posedge iCLOCK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device-side model: combinational read data, write capture and protocol watch.
  logic [31:0] dev_size [N];
  logic [31:0] dev_pri  [N];
  logic [31:0] dev_base [N];
  int          dev_wcnt [N] = '{default: 0};
  int          dev_wcyc [N] = '{default: 0};
  int          viol = 0;
  logic [N-1:0] prev_wsel = '0;

  always_comb begin
    sp.iSPECIAL_DATA = '0;
    for (int i = 0; i < N; i++) begin
      if (sp.oSPECIAL_REQ && !sp.oSPECIAL_RW && sp.oSPECIAL_SEL[i]) begin
        case (sp.oSPECIAL_ADDR)
          8'h00:   sp.iSPECIAL_DATA = dev_size[i];
          8'h01:   sp.iSPECIAL_DATA = dev_pri[i];
          default: sp.iSPECIAL_DATA = '0;
        endcase
      end
    end
  end

  always @(negedge iCLOCK) begin : mon
    int v;
    v = 0;
    if (inRESET) begin
      if (!sp.oSPECIAL_REQ && sp.oSPECIAL_SEL != '0) v++;
      if (sp.oSPECIAL_REQ && !$onehot(sp.oSPECIAL_SEL)) v++;
      if (sp.oSPECIAL_REQ && sp.oSPECIAL_RW && sp.oSPECIAL_ADDR != 8'h02) v++;
      if (sp.oSPECIAL_REQ && sp.oSPECIAL_RW && sp.oSPECIAL_SEL == prev_wsel) v++;
      for (int i = 0; i < N; i++) begin
        if (sp.oSPECIAL_REQ && sp.oSPECIAL_RW && sp.oSPECIAL_SEL[i]) begin
          dev_base[i] <= sp.oSPECIAL_DATA;
          dev_wcnt[i] <= dev_wcnt[i] + 1;
          dev_wcyc[i] <= cyc;
        end
      end
      prev_wsel <= (sp.oSPECIAL_REQ && sp.oSPECIAL_RW) ? sp.oSPECIAL_SEL : '0;
      viol <= viol + v;
    end
  end

  // Reference allocation: a running pointer, wide enough that a carry is just a bigger number.
  logic [31:0] exp_base  [N];
  logic        exp_valid [N];
  logic        exp_err;

  task automatic model();
    longint ptr;
    ptr     = longint'(BASE);
    exp_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_base[k]  = '0;
      exp_valid[k] = 1'b0;
      if (dev_size[k] != 0) begin
        if (exp_err || (ptr + longint'(dev_size[k]) > longint'(LIMIT))) begin
          exp_err = 1'b1;
        end else begin
          exp_base[k]  = 32'(ptr);
          exp_valid[k] = 1'b1;
          ptr          = ptr + longint'(dev_size[k]);
        end
      end
    end
  endtask

  task automatic set_sizes(input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3);
    dev_size[0] = s0; dev_size[1] = s1; dev_size[2] = s2; dev_size[3] = s3;
    for (int k = 0; k < N; k++) dev_pri[k] = $urandom;
  endtask

  int last_acc  = 0;
  int last_dabs = 0;

  task automatic do_scan(input int ign);
    int  k, c;
    int  wc0 [N];
    int  v0;
    bit  found;
    for (int i = 0; i < N; i++) wc0[i] = dev_wcnt[i];
    v0 = viol;
    model();
    iSTART = 1'b1;
    k = 0;
    while (oBUSY && k < 100) begin
      @(negedge iCLOCK);
      k++;
    end
    @(posedge iCLOCK);
    #1;
    iSTART   = 1'b0;
    last_acc = cyc;
    c = 1;
    found = 1'b0;
    while (!found && c <= 60) begin
      @(negedge iCLOCK);
      iSTART = (c == ign);
      if (c == 1) begin
        chk("busy_c1", oBUSY, 1);
        chk("err_clr", oERROR, 0);
      end
      if (oDONE) begin
        found     = 1'b1;
        last_dabs = cyc;
      end else begin
        c++;
      end
    end
    iSTART = 1'b0;
    chk("done_cyc", c, 4 * N + 1);
    chk("busy_done", oBUSY, 1);
    chk("error", oERROR, exp_err);
    chk("proto", viol - v0, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("wcnt%0d", i), dev_wcnt[i] - wc0[i], 1);
      chk($sformatf("wbase%0d", i), dev_base[i], exp_base[i]);
      chk($sformatf("wcyc%0d", i), dev_wcyc[i] - last_acc + 1, 4 * i + 4);
    end
    for (int i = 0; i < N; i++) begin
      iTBL_ID = 4'(i);
      #1;
      chk($sformatf("tvalid%0d", i), oTBL_VALID, exp_valid[i]);
      chk($sformatf("tbase%0d", i), oTBL_BASE, exp_base[i]);
      chk($sformatf("tsize%0d", i), oTBL_SIZE, dev_size[i]);
      chk($sformatf("tpri%0d", i), oTBL_PRIORITY, dev_pri[i]);
    end
    iTBL_ID = 4'd4;
    #1;
    chk("toor4", oTBL_BASE | oTBL_SIZE | oTBL_PRIORITY | {31'b0, oTBL_VALID}, 0);
    iTBL_ID = 4'd15;
    #1;
    chk("toor15", oTBL_BASE | oTBL_SIZE | oTBL_PRIORITY | {31'b0, oTBL_VALID}, 0);
  endtask

  initial begin : watchdog
    #(100 * 5000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pd;
    int rc0 [N];
    logic [31:0] s [N];

    repeat (2) @(negedge iCLOCK);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_err", oERROR, 0);
    chk("rst_req", sp.oSPECIAL_REQ, 0);
    chk("rst_rw", sp.oSPECIAL_RW, 0);
    chk("rst_sel", sp.oSPECIAL_SEL, 0);
    chk("rst_addr", sp.oSPECIAL_ADDR, 0);
    chk("rst_data", sp.oSPECIAL_DATA, 0);
    chk("rst_tvalid", oTBL_VALID, 0);
    inRESET = 1'b1;
    repeat (2) @(negedge iCLOCK);

    set_sizes(32'h100, 32'h200, 32'h40, 32'h80);
    do_scan(0);
    chk("tp_base0", dev_base[0], 32'h1000);
    chk("tp_base3", dev_base[3], 32'h1340);

    pd = last_dabs;
    do_scan(0);
    chk("b2b_acc", last_acc, pd + 2);

    set_sizes(32'h100, 32'h0, 32'h40, 32'h80);
    do_scan(0);
    chk("zero_base2", dev_base[2], 32'h1100);

    set_sizes(32'h8000, 32'h9000, 32'h10, 32'h10);
    do_scan(0);
    repeat (3) @(negedge iCLOCK);
    chk("err_sticky", oERROR, 1);

    set_sizes(32'hF000, 32'h0, 32'h1, 32'h0);
    do_scan(0);

    set_sizes(32'h20, 32'hFFFF_FFF0, 32'h0, 32'h10);
    do_scan(0);
    chk("carry_base1", dev_base[1], 32'h0);

    set_sizes(32'h100, 32'h200, 32'h40, 32'h80);
    do_scan(6);

    repeat (6) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       s[k] = 32'h0;
          1:       s[k] = $urandom_range(1, 32'h3000);
          2:       s[k] = $urandom;
          default: s[k] = $urandom_range(1, 32'h8000);
        endcase
      end
      set_sizes(s[0], s[1], s[2], s[3]);
      do_scan($urandom_range(0, 20));
    end

    // Reset landing in device 2's priority read.
    set_sizes(32'h100, 32'h200, 32'h40, 32'h80);
    repeat (2) @(negedge iCLOCK);
    for (int i = 0; i < N; i++) rc0[i] = dev_wcnt[i];
    iSTART = 1'b1;
    @(posedge iCLOCK);
    #1;
    iSTART = 1'b0;
    repeat (10) @(negedge iCLOCK);
    chk("prerst_addr", sp.oSPECIAL_ADDR, 8'h01);
    chk("prerst_sel", sp.oSPECIAL_SEL, 4'b0100);
    inRESET = 1'b0;
    #1;
    chk("mrst_req", sp.oSPECIAL_REQ, 0);
    chk("mrst_sel", sp.oSPECIAL_SEL, 0);
    chk("mrst_addr", sp.oSPECIAL_ADDR, 0);
    chk("mrst_busy", oBUSY, 0);
    iTBL_ID = 4'd0;
    #1;
    chk("mrst_tvalid", oTBL_VALID, 0);
    chk("mrst_tbase", oTBL_BASE, 0);
    repeat (5) @(negedge iCLOCK);
    chk("mrst_w0", dev_wcnt[0] - rc0[0], 1);
    chk("mrst_w1", dev_wcnt[1] - rc0[1], 1);
    chk("mrst_w2", dev_wcnt[2] - rc0[2], 0);
    chk("mrst_w3", dev_wcnt[3] - rc0[3], 0);
    chk("mrst_b1", dev_base[1], 32'h1100);
    inRESET = 1'b1;
    repeat (2) @(negedge iCLOCK);

    do_scan(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
